// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer for the 32-bit MIPS-style core: steps the shared datapath
// through FETCH/DECODE/EXEC/MEM/WB and stalls on the shared memory's ready handshake.
module mc_sequencer (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic       Run,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       alu_src,
    output logic       mem_to_reg,
    output logic [1:0] reg_dst,
    output logic [1:0] pc_src,
    output logic [3:0] alu_op,
    output logic [2:0] branch_type,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_GTZ  = 3'd3,
        BR_LEZ  = 3'd4
    } br_t;

    typedef enum logic [3:0] {
        C_BAD,
        C_RTYPE,
        C_JR,
        C_IMM,
        C_LW,
        C_SW,
        C_BR,
        C_J,
        C_JAL
    } iclass_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fn_q, fn_d;
    logic       illegal_q, illegal_d;

    iclass_t    cls;
    alu_op_t    dec_alu;
    br_t        dec_br;
    state_t     boundary;

    // Decode works only from the latched op so outputs never follow the memory bus
    always_comb begin
        cls     = C_BAD;
        dec_alu = ALU_ADD;
        dec_br  = BR_NONE;
        case (op_q)
            6'h00: begin
                cls = C_RTYPE;
                case (fn_q)
                    6'h20:   dec_alu = ALU_ADD;
                    6'h22:   dec_alu = ALU_SUB;
                    6'h24:   dec_alu = ALU_AND;
                    6'h25:   dec_alu = ALU_OR;
                    6'h2A:   dec_alu = ALU_SLT;
                    6'h00:   dec_alu = ALU_SLL;
                    6'h02:   dec_alu = ALU_SRL;
                    6'h08:   cls     = C_JR;
                    default: cls     = C_BAD;
                endcase
            end
            6'h02: cls = C_J;
            6'h03: cls = C_JAL;
            6'h08: begin cls = C_IMM; dec_alu = ALU_ADD; end
            6'h0C: begin cls = C_IMM; dec_alu = ALU_AND; end
            6'h0D: begin cls = C_IMM; dec_alu = ALU_OR;  end
            6'h0A: begin cls = C_IMM; dec_alu = ALU_SLT; end
            6'h23: cls = C_LW;
            6'h2B: cls = C_SW;
            6'h04: begin cls = C_BR; dec_br = BR_EQ;  end
            6'h05: begin cls = C_BR; dec_br = BR_NE;  end
            6'h07: begin cls = C_BR; dec_br = BR_GTZ; end
            6'h06: begin cls = C_BR; dec_br = BR_LEZ; end
            default: cls = C_BAD;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        fn_d        = fn_q;
        illegal_d   = illegal_q;
        boundary    = Run ? S_FETCH : S_IDLE;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 2'd0;
        pc_src      = 2'd0;
        alu_op      = ALU_ADD;
        branch_type = BR_NONE;

        case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    op_d     = opcode;
                    fn_d     = funct;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (cls)
                    C_J: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        state_d  = boundary;
                    end
                    C_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                        reg_write = 1'b1;
                        reg_dst   = 2'd2;
                        state_d   = boundary;
                    end
                    C_BAD: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_RTYPE: begin
                        alu_op  = dec_alu;
                        state_d = S_WB;
                    end
                    C_JR: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd3;
                        state_d  = boundary;
                    end
                    C_IMM: begin
                        alu_op  = dec_alu;
                        alu_src = 1'b1;
                        state_d = S_WB;
                    end
                    C_LW, C_SW: begin
                        alu_op  = ALU_ADD;
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    C_BR: begin
                        alu_op      = ALU_SUB;
                        branch_type = dec_br;
                        pc_src      = 2'd1;
                        pc_write    = branch_taken;
                        state_d     = boundary;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (cls == C_LW);
                mem_write = (cls == C_SW);
                if (mem_ready) state_d = (cls == C_LW) ? S_WB : boundary;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (cls == C_RTYPE) ? 2'd1 : 2'd0;
                mem_to_reg = (cls == C_LW);
                state_d    = boundary;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            fn_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            fn_q      <= fn_d;
            illegal_q <= illegal_d;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: each driven cycle pushes the expected output vector,
// and a negedge monitor pops and compares it against the DUT.
module tb_mc_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       Reset, Run, mem_ready, branch_taken;
    logic [5:0] opcode, funct;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d, alu_src, mem_to_reg;
    logic [1:0] reg_dst, pc_src;
    logic [3:0] alu_op;
    logic [2:0] branch_type, state;
    logic       illegal;

    localparam logic [7:0] PCW  = 8'b1000_0000;
    localparam logic [7:0] IRW  = 8'b0100_0000;
    localparam logic [7:0] RW   = 8'b0010_0000;
    localparam logic [7:0] MR   = 8'b0001_0000;
    localparam logic [7:0] MW   = 8'b0000_1000;
    localparam logic [7:0] IOD  = 8'b0000_0100;
    localparam logic [7:0] ASRC = 8'b0000_0010;
    localparam logic [7:0] M2R  = 8'b0000_0001;
    localparam logic [5:0] G    = 6'h3F;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [22:0] exp_q[$];
    string       tag_q[$];
    logic [22:0] obs;

    mc_sequencer dut (
        .CLOCK_50    (CLOCK_50),
        .Reset       (Reset),
        .Run         (Run),
        .opcode      (opcode),
        .funct       (funct),
        .mem_ready   (mem_ready),
        .branch_taken(branch_taken),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .i_or_d      (i_or_d),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .pc_src      (pc_src),
        .alu_op      (alu_op),
        .branch_type (branch_type),
        .state       (state),
        .illegal     (illegal)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    assign obs = {state, illegal, pc_write, ir_write, reg_write, mem_read, mem_write,
                  i_or_d, alu_src, mem_to_reg, reg_dst, pc_src, alu_op, branch_type};

    function automatic logic [22:0] ev(input logic [2:0] st, input logic [7:0] sb,
                                       input logic [1:0] rd, input logic [1:0] ps,
                                       input logic [3:0] ao, input logic [2:0] bt);
        return {st, (st == 3'd7), sb, rd, ps, ao, bt};
    endfunction

    task automatic check_eq(input string tag, input logic [22:0] got, input logic [22:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h (st=%0d) expected %h (st=%0d)", tag, got, got[22:20], exp, exp[22:20]);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (exp_q.size() > 0) check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
    end

    task automatic step(input string tag, input logic run, input logic rdy, input logic bt,
                        input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic [22:0] e, input logic chk);
        Run = run; mem_ready = rdy; branch_taken = bt; Reset = rst;
        opcode = op; funct = fn;
        if (chk) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0; funct = '0;
        step("rst0", 0, 0, 0, 1, G, G, '0, 0);
        step("rst1", 0, 0, 0, 1, G, G, '0, 0);
        step("reset_idle", 0, 1, 1, 0, G, G, ev(0, 0, 0, 0, 0, 0), 1);

        // add $3,$1,$2 zero wait
        step("add_idle", 1, 0, 0, 0, G, G, ev(0, 0, 0, 0, 0, 0), 1);
        step("add_fetch", 1, 1, 0, 0, 6'h00, 6'h20, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("add_dec", 1, 0, 1, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("add_exec", 1, 1, 1, 0, G, G, ev(3, 0, 0, 0, 0, 0), 1);
        step("add_wb", 1, 0, 0, 0, G, G, ev(5, RW, 1, 0, 0, 0), 1);

        // lw: 2 FETCH waits, 1 MEM wait -> 8 cycles
        step("lw_f0", 1, 0, 0, 0, 6'h23, G, ev(1, MR, 0, 0, 0, 0), 1);
        step("lw_f1", 1, 0, 0, 0, 6'h23, G, ev(1, MR, 0, 0, 0, 0), 1);
        step("lw_f2", 1, 1, 0, 0, 6'h23, 6'h15, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("lw_dec", 1, 0, 0, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("lw_exec", 1, 0, 0, 0, G, G, ev(3, ASRC, 0, 0, 0, 0), 1);
        step("lw_mem0", 1, 0, 0, 0, G, G, ev(4, MR|IOD, 0, 0, 0, 0), 1);
        step("lw_mem1", 1, 1, 0, 0, G, G, ev(4, MR|IOD, 0, 0, 0, 0), 1);
        step("lw_wb", 1, 0, 0, 0, G, G, ev(5, RW|M2R, 0, 0, 0, 0), 1);

        // sw zero wait
        step("sw_fetch", 1, 1, 0, 0, 6'h2B, 6'h00, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("sw_dec", 1, 0, 0, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("sw_exec", 1, 0, 0, 0, G, G, ev(3, ASRC, 0, 0, 0, 0), 1);
        step("sw_mem", 1, 1, 0, 0, G, G, ev(4, MW|IOD, 0, 0, 0, 0), 1);

        // bne taken
        step("bne_fetch", 1, 1, 1, 0, 6'h05, G, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("bne_dec", 1, 0, 1, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("bne_exec", 1, 0, 1, 0, G, G, ev(3, PCW, 0, 1, 1, 2), 1);

        // beq not taken
        step("beq_fetch", 1, 1, 1, 0, 6'h04, G, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("beq_dec", 1, 0, 1, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("beq_exec", 1, 0, 0, 0, G, G, ev(3, 0, 0, 1, 1, 1), 1);

        // blez taken, bgtz not taken
        step("blez_fetch", 1, 1, 0, 0, 6'h06, G, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("blez_dec", 1, 0, 0, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("blez_exec", 1, 0, 1, 0, G, G, ev(3, PCW, 0, 1, 1, 4), 1);
        step("bgtz_fetch", 1, 1, 0, 0, 6'h07, G, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("bgtz_dec", 1, 0, 0, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("bgtz_exec", 1, 0, 0, 0, G, G, ev(3, 0, 0, 1, 1, 3), 1);

        // jr
        step("jr_fetch", 1, 1, 0, 0, 6'h00, 6'h08, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("jr_dec", 1, 0, 0, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("jr_exec", 1, 0, 0, 0, G, G, ev(3, PCW, 0, 3, 0, 0), 1);

        // ori, slt, srl
        step("ori_fetch", 1, 1, 0, 0, 6'h0D, G, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("ori_dec", 1, 0, 0, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("ori_exec", 1, 0, 0, 0, G, G, ev(3, ASRC, 0, 0, 3, 0), 1);
        step("ori_wb", 1, 0, 0, 0, G, G, ev(5, RW, 0, 0, 0, 0), 1);
        step("slt_fetch", 1, 1, 0, 0, 6'h00, 6'h2A, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("slt_dec", 1, 0, 0, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("slt_exec", 1, 0, 0, 0, G, G, ev(3, 0, 0, 0, 4, 0), 1);
        step("slt_wb", 1, 0, 0, 0, G, G, ev(5, RW, 1, 0, 0, 0), 1);
        step("srl_fetch", 1, 1, 0, 0, 6'h00, 6'h02, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("srl_dec", 1, 0, 0, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("srl_exec", 1, 0, 0, 0, G, G, ev(3, 0, 0, 0, 6, 0), 1);
        step("srl_wb", 1, 0, 0, 0, G, G, ev(5, RW, 1, 0, 0, 0), 1);

        // jal then Run=0 -> IDLE and stays
        step("jal_fetch", 1, 1, 0, 0, 6'h03, G, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("jal_dec", 0, 0, 0, 0, G, G, ev(2, PCW|RW, 2, 2, 0, 0), 1);
        for (int i = 0; i < 3; i++)
            step("jal_idle", 0, 1, 1, 0, G, G, ev(0, 0, 0, 0, 0, 0), 1);

        // reset during lw MEM wait
        step("rm_idle", 1, 0, 0, 0, G, G, ev(0, 0, 0, 0, 0, 0), 1);
        step("rm_fetch", 1, 1, 0, 0, 6'h23, G, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("rm_dec", 1, 0, 0, 0, G, G, ev(2, 0, 0, 0, 0, 0), 1);
        step("rm_exec", 1, 0, 0, 0, G, G, ev(3, ASRC, 0, 0, 0, 0), 1);
        step("rm_mem", 1, 0, 0, 1, G, G, ev(4, MR|IOD, 0, 0, 0, 0), 1);
        step("rm_after0", 0, 1, 0, 0, G, G, ev(0, 0, 0, 0, 0, 0), 1);
        step("rm_after1", 0, 1, 0, 0, G, G, ev(0, 0, 0, 0, 0, 0), 1);

        // illegal opcode 0x3F -> TRAP, sticky until Reset
        step("ill_idle", 1, 0, 0, 0, G, G, ev(0, 0, 0, 0, 0, 0), 1);
        step("ill_fetch", 1, 1, 0, 0, 6'h3F, 6'h20, ev(1, PCW|IRW|MR, 0, 0, 0, 0), 1);
        step("ill_dec", 1, 0, 0, 0, 6'h00, 6'h20, ev(2, 0, 0, 0, 0, 0), 1);
        for (int i = 0; i < 11; i++)
            step("ill_trap", 1, 1, 1, 0, 6'h00, 6'h20, ev(7, 0, 0, 0, 0, 0), 1);
        step("ill_rst", 1, 1, 0, 1, G, G, ev(7, 0, 0, 0, 0, 0), 1);
        step("ill_cleared", 0, 0, 0, 0, G, G, ev(0, 0, 0, 0, 0, 0), 1);

        @(negedge CLOCK_50);
        check_eq("drain", 23'(exp_q.size()), 23'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
# mc_sequencer

Multi-cycle control sequencer for the 32-bit MIPS-style core. It replaces the single-cycle decoder with an FSM that steps one shared datapath through FETCH/DECODE/EXEC/MEM/WB. It drives the datapath write strobes and mux selects, and stalls on a shared instruction/data memory via a ready handshake. It sits between the `process` datapath and the memory wrapper.

## Interface
- No parameters; encodings fixed below.
- `CLOCK_50` in 1: sole clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Run` in 1: enables execution; sampled at instruction boundaries.
- `opcode` in 6: instr[31:26] from memory read data.
- `funct` in 6: instr[5:0] from memory read data.
- `mem_ready` in 1: memory completes the current access this cycle.
- `branch_taken` in 1: datapath comparator result for the `branch_type` currently driven.
- `pc_write`, `ir_write`, `reg_write` out 1: write strobes.
- `mem_read`, `mem_write` out 1: memory request, held until `mem_ready`.
- `i_or_d` out 1: 0 = PC addresses memory, 1 = ALU result addresses memory.
- `alu_src` out 1: 1 = sign-extended immediate.
- `mem_to_reg` out 1: 1 = memory data is written back.
- `reg_dst` out 2: write destination. 0 = rt, 1 = rd, 2 = r31.
- `pc_src` out 2: next-PC select. 0 = PC+4, 1 = branch target, 2 = jump, 3 = rs (jr).
- `alu_op` out 4: ALU operation. ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, SRL=6.
- `branch_type` out 3: branch condition. none=0, eq=1, ne=2, gtz=3, lez=4.
- `state` out 3: current state. IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- `illegal` out 1: sticky; set on an undecodable instruction.

## Operation
- **Op latch.** `opcode` and `funct` are captured into internal registers on the FETCH edge where `mem_ready`=1, the same edge as `ir_write`. All outputs are a combinational function of `state` and the latched op only.
- **IDLE.** All strobes 0.
  - `Run`=1 → FETCH.
- **FETCH.** `mem_read`=1, `i_or_d`=0.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=0; then → DECODE.
  - Otherwise stay in FETCH.
- **DECODE.** Registers are read.
  - j (0x02): `pc_write`=1, `pc_src`=2; → boundary.
  - jal (0x03): `pc_write`=1, `pc_src`=2, `reg_write`=1, `reg_dst`=2 (writes PC+4); → boundary.
  - Any other supported op → EXEC.
  - Unsupported opcode/funct → TRAP.
- **EXEC.**
  - R-type (op 0x00): funct add 0x20→ADD, sub 0x22→SUB, and 0x24→AND, or 0x25→OR, slt 0x2A→SLT, sll 0x00→SLL, srl 0x02→SRL; `alu_src`=0; → WB.
  - jr (funct 0x08): `pc_write`=1, `pc_src`=3; → boundary.
  - addi 0x08→ADD, andi 0x0C→AND, ori 0x0D→OR, slti 0x0A→SLT; all with `alu_src`=1; → WB.
  - lw 0x23, sw 0x2B: ADD, `alu_src`=1; → MEM.
  - beq 0x04, bne 0x05, bgtz 0x07, blez 0x06: SUB, `branch_type` = 1/2/3/4; `pc_write`=`branch_taken`, `pc_src`=1; → boundary.
- **MEM.** `i_or_d`=1; `mem_read`=1 for lw, `mem_write`=1 for sw.
  - On `mem_ready`: lw → WB; sw → boundary.
- **WB.** `reg_write`=1.
  - R-type: `reg_dst`=1, `mem_to_reg`=0.
  - Immediate ops: `reg_dst`=0, `mem_to_reg`=0.
  - lw: `reg_dst`=0, `mem_to_reg`=1.
  - → boundary.
- **Boundary.** Next state is FETCH if `Run`=1, else IDLE. `Run` is ignored mid-instruction.
- **TRAP.** All strobes 0, `illegal`=1. Exits only via `Reset`.
- **Inactive outputs.** Every output not listed for a state is 0.

## Timing
- **Reset.** Reset takes effect on the rising edge where `Reset`=1, from any state, including mid-memory-access. After that edge: `state`=IDLE, `illegal`=0, latched op=0, all outputs 0. No strobe is asserted in the cycle following reset.
- **Memory waits.** Each FETCH/MEM wait cycle with `mem_ready`=0 adds one cycle. Requests stay asserted and unchanged during waits. `pc_write`/`ir_write` fire only on the ready cycle.
- **Instruction latency with zero wait states:**
  - j/jal: 2 cycles.
  - Branch/jr: 3 cycles.
  - R-type/immediate/sw: 4 cycles.
  - lw: 5 cycles.
- **Strobe width.** Each write strobe is exactly one cycle per instruction.
- **`mem_ready` outside FETCH/MEM** is ignored.
- **`branch_taken`** is sampled only in EXEC of a branch.

## Test plan
- **Reset mid-MEM.** `Reset`=1 during lw MEM with `mem_ready`=0 → next cycle `state`=0, `mem_read`=0, `reg_write` never asserts.
- **add $3,$1,$2 (0x00221820), zero wait.** Expected state sequence 1,2,3,5,1. `alu_op`=0 in EXEC; `reg_write`=1 with `reg_dst`=1 only in WB.
- **lw (op 0x23) with 2 wait cycles in FETCH and 1 in MEM.** Expected 8 cycles. `ir_write` pulses once, on the third FETCH cycle. WB has `mem_to_reg`=1.
- **Branches.**
  - bne with `branch_taken`=1 → EXEC has `branch_type`=2, `pc_write`=1, `pc_src`=1.
  - beq with `branch_taken`=0 → `pc_write`=0.
- **jal then `Run`=0.** DECODE asserts `pc_write`=1, `reg_write`=1, `reg_dst`=2. Next state is IDLE, and it stays there until `Run`=1.
- **Illegal opcode 0x3F.** → TRAP with `illegal`=1 held for 10+ cycles; `Reset` clears it to IDLE.
